// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-style datapath: PC/IR/MDR/A/B/ALUOut pipeline registers, 32x32 register file,
// ALU and next-PC selection, all steered by an external microprogrammed controller.
module multicycle_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        IRWrite,
  input  logic        ALUSrcA,
  input  logic        PCWriteCond,
  input  logic        BranchNotEqual,
  input  logic        PCWrite,
  input  logic        IorD,
  input  logic [1:0]  RegDst,
  input  logic [1:0]  MemtoReg,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSrc,
  input  logic [1:0]  ALUOp,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [5:0]  opcode,
  output logic        zero,
  output logic [31:0] pc_out
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT
  } alu_ctl_e;

  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [31:0] rf [32];

  logic [4:0]  rs, rt, rd;
  logic [31:0] rd_a, rd_b;
  logic [31:0] imm_ext, imm_br;
  logic [31:0] src_a, src_b, alu_y;
  alu_ctl_e    alu_ctl;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign opcode = ir[31:26];

  assign rd_a = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd_b = (rt == 5'd0) ? 32'd0 : rf[rt];

  // andi/ori treat their immediate as unsigned; everything else sign-extends
  assign imm_ext = ((opcode == 6'h0C) || (opcode == 6'h0D)) ?
                   {16'd0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
  assign imm_br  = {{14{ir[15]}}, ir[15:0], 2'b00};

  assign src_a = ALUSrcA ? a : pc;

  always_comb begin
    src_b = b;
    case (ALUSrcB)
      2'b00: src_b = b;
      2'b01: src_b = 32'd4;
      2'b10: src_b = imm_ext;
      2'b11: src_b = imm_br;
      default: src_b = b;
    endcase
  end

  always_comb begin
    alu_ctl = ALU_ADD;
    case (ALUOp)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      2'b10: begin
        case (ir[5:0])
          6'h22:   alu_ctl = ALU_SUB;
          6'h24:   alu_ctl = ALU_AND;
          6'h25:   alu_ctl = ALU_OR;
          6'h27:   alu_ctl = ALU_NOR;
          6'h2A:   alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      2'b11: begin
        case (opcode)
          6'h0C:   alu_ctl = ALU_AND;
          6'h0D:   alu_ctl = ALU_OR;
          6'h0A:   alu_ctl = ALU_SLT;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_y = src_a + src_b;
    case (alu_ctl)
      ALU_ADD: alu_y = src_a + src_b;
      ALU_SUB: alu_y = src_a - src_b;
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_NOR: alu_y = ~(src_a | src_b);
      ALU_SLT: alu_y = {31'd0, ($signed(src_a) < $signed(src_b))};
      default: alu_y = src_a + src_b;
    endcase
  end

  assign zero = (alu_y == 32'd0);

  always_comb begin
    pc_next = alu_y;
    case (PCSrc)
      2'b00: pc_next = alu_y;
      2'b01: pc_next = alu_out;
      2'b10: pc_next = {pc[31:28], ir[25:0], 2'b00};
      2'b11: pc_next = a;
      default: pc_next = alu_y;
    endcase
  end

  assign pc_we = PCWrite | (PCWriteCond & (zero ^ BranchNotEqual));

  always_comb begin
    rf_waddr = rt;
    case (RegDst)
      2'b00: rf_waddr = rt;
      2'b01: rf_waddr = rd;
      2'b10: rf_waddr = 5'd31;
      2'b11: rf_waddr = 5'd0;
      default: rf_waddr = rt;
    endcase
  end

  always_comb begin
    rf_wdata = alu_out;
    case (MemtoReg)
      2'b00: rf_wdata = alu_out;
      2'b01: rf_wdata = mdr;
      2'b10: rf_wdata = pc;
      2'b11: rf_wdata = 32'd0;
      default: rf_wdata = alu_out;
    endcase
  end

  // RegDst=11 means "no destination"; index 0 is hardwired to zero
  assign rf_we = RegWrite && (RegDst != 2'b11) && (rf_waddr != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= 32'd0;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      if (IRWrite) ir <= mem_rdata;
      mdr     <= mem_rdata;
      a       <= rd_a;
      b       <= rd_b;
      alu_out <= alu_y;
      if (pc_we) pc <= pc_next;
      if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
  end

  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b;
  assign mem_rd    = MemRead;
  assign mem_wr    = MemWrite;
  assign pc_out    = pc;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: drives controller strobes cycle by cycle and
// compares the visible ports against hand-computed values.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, RegWrite, IRWrite, ALUSrcA, PCWriteCond, BranchNotEqual, PCWrite, IorD;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOp;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rd, mem_wr;
  logic [5:0]  opcode;
  logic        zero;
  logic [31:0] pc_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] res;

  multicycle_datapath dut (
    .clk(clk), .rst(rst),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .PCWriteCond(PCWriteCond), .BranchNotEqual(BranchNotEqual),
    .PCWrite(PCWrite), .IorD(IorD),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .opcode(opcode), .zero(zero), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    MemRead = 0; MemWrite = 0; RegWrite = 0; IRWrite = 0; ALUSrcA = 0;
    PCWriteCond = 0; BranchNotEqual = 0; PCWrite = 0; IorD = 0;
    RegDst = 2'b00; MemtoReg = 2'b00; ALUSrcB = 2'b00; PCSrc = 2'b00; ALUOp = 2'b00;
  endtask

  // IR load, then one more edge so A/B reflect the new rs/rt
  task automatic load_ir(input logic [31:0] v);
    IRWrite = 1; mem_rdata = v;
    tick();
    IRWrite = 0;
    tick();
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
    load_ir({6'h23, 5'd0, idx, 16'h0000});
    mem_rdata = val;
    tick();
    RegDst = 2'b00; MemtoReg = 2'b01; RegWrite = 1;
    tick();
    idle();
  endtask

  task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
    load_ir({6'h00, 5'd0, idx, 16'h0000});
    val = mem_wdata;
  endtask

  task automatic alu_run(input logic [31:0] ir_v, input logic [1:0] srcb, input logic [1:0] op,
                         output logic [31:0] r);
    load_ir(ir_v);
    ALUSrcA = 1; ALUSrcB = srcb; ALUOp = op;
    tick();
    idle();
    IorD = 1;
    #1;
    r = mem_addr;
    IorD = 0;
  endtask

  initial begin
    idle();
    mem_rdata = 32'd0;
    rst = 1;
    #12;
    ALUSrcA = 0; ALUSrcB = 2'b01;
    #1;
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_zero_pc4", {31'd0, zero}, 32'd0);
    ALUSrcB = 2'b00;
    #1;
    chk("rst_zero_pcb", {31'd0, zero}, 32'd1);
    idle();
    rst = 0;

    // fetch
    mem_rdata = 32'h2008_0005;
    IRWrite = 1; PCWrite = 1; ALUSrcA = 0; ALUSrcB = 2'b01; PCSrc = 2'b00;
    tick();
    idle();
    chk("fetch_pc", pc_out, 32'd4);
    chk("fetch_opcode", {26'd0, opcode}, 32'h08);
    ALUSrcB = 2'b10;
    tick();
    idle();
    IorD = 1;
    #1;
    chk("fetch_imm_sum", mem_addr, 32'd9);
    IorD = 0;

    // R-type
    write_reg(5'd9, 32'd7);
    write_reg(5'd10, 32'd3);
    alu_run(32'h012A_5822, 2'b00, 2'b10, res); chk("r_sub", res, 32'd4);
    RegDst = 2'b01; MemtoReg = 2'b00; RegWrite = 1;
    tick();
    idle();
    read_reg(5'd11, res); chk("rf11_wb", res, 32'd4);
    alu_run(32'h012A_5820, 2'b00, 2'b10, res); chk("r_add", res, 32'd10);
    alu_run(32'h012A_5824, 2'b00, 2'b10, res); chk("r_and", res, 32'd3);
    alu_run(32'h012A_5825, 2'b00, 2'b10, res); chk("r_or", res, 32'd7);
    alu_run(32'h012A_5827, 2'b00, 2'b10, res); chk("r_nor", res, 32'hFFFF_FFF8);
    alu_run(32'h012A_582A, 2'b00, 2'b10, res); chk("r_slt_0", res, 32'd0);
    alu_run(32'h0149_582A, 2'b00, 2'b10, res); chk("r_slt_1", res, 32'd1);
    alu_run(32'h012A_5800, 2'b00, 2'b10, res); chk("r_funct_dflt", res, 32'd10);

    // write RF[9] while A reads RF[9]: A must see the old value 7
    alu_run(32'h012A_4820, 2'b00, 2'b10, res); chk("r_add_self", res, 32'd10);
    RegDst = 2'b01; MemtoReg = 2'b00; RegWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b01; ALUOp = 2'b00;
    tick();
    RegWrite = 0;
    tick();
    idle();
    IorD = 1;
    #1;
    chk("rw_same_cycle_old", mem_addr, 32'd11);
    IorD = 0;
    read_reg(5'd9, res); chk("rf9_new", res, 32'd10);

    // beq / bne
    write_reg(5'd12, 32'd5);
    write_reg(5'd13, 32'd5);
    load_ir(32'h118D_000F);
    ALUSrcA = 0; ALUSrcB = 2'b11; ALUOp = 2'b00;
    tick();
    idle();
    ALUSrcA = 1; ALUSrcB = 2'b00; ALUOp = 2'b01; PCWriteCond = 1; PCSrc = 2'b01;
    #1;
    chk("beq_zero", {31'd0, zero}, 32'd1);
    tick();
    idle();
    chk("beq_taken_pc", pc_out, 32'h40);
    ALUSrcA = 0; ALUSrcB = 2'b11; ALUOp = 2'b00;
    tick();
    idle();
    ALUSrcA = 1; ALUSrcB = 2'b00; ALUOp = 2'b01; PCWriteCond = 1; PCSrc = 2'b01; BranchNotEqual = 1;
    tick();
    idle();
    chk("bne_not_taken_pc", pc_out, 32'h40);

    // sw / lw
    write_reg(5'd14, 32'h100);
    write_reg(5'd15, 32'hDEAD_BEEF);
    alu_run(32'hADCF_FFFC, 2'b10, 2'b00, res); chk("sw_ea", res, 32'hFC);
    IorD = 1; MemWrite = 1;
    #1;
    chk("sw_addr", mem_addr, 32'hFC);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_wr", {31'd0, mem_wr}, 32'd1);
    MemWrite = 0; MemRead = 1; mem_rdata = 32'h1234_5678;
    #1;
    chk("lw_rd", {31'd0, mem_rd}, 32'd1);
    tick();
    MemRead = 0; IorD = 0; RegDst = 2'b00; MemtoReg = 2'b01; RegWrite = 1;
    tick();
    idle();
    read_reg(5'd15, res); chk("lw_rf15", res, 32'h1234_5678);

    // immediates
    alu_run(32'h3400_8000, 2'b10, 2'b11, res); chk("ori_zext", res, 32'h0000_8000);
    RegDst = 2'b00; MemtoReg = 2'b00; RegWrite = 1;
    tick();
    idle();
    read_reg(5'd0, res); chk("rf0_stays_0", res, 32'd0);
    alu_run(32'h2000_8000, 2'b10, 2'b11, res); chk("addi_sext", res, 32'hFFFF_8000);
    alu_run(32'h2800_0001, 2'b10, 2'b11, res); chk("slti", res, 32'd1);

    // jump to 0x24, then async reset between edges
    load_ir(32'h0800_0009);
    PCWrite = 1; PCSrc = 2'b10;
    tick();
    idle();
    chk("j_pc", pc_out, 32'h24);
    #2;
    rst = 1;
    #1;
    chk("async_rst_pc", pc_out, 32'd0);
    chk("async_rst_opcode", {26'd0, opcode}, 32'd0);
    tick();
    chk("rst_hold_pc", pc_out, 32'd0);
    rst = 0;

    // jal-style link after release
    mem_rdata = 32'h0C00_0009;
    IRWrite = 1; PCWrite = 1; ALUSrcA = 0; ALUSrcB = 2'b01; PCSrc = 2'b00;
    tick();
    idle();
    chk("post_rst_pc", pc_out, 32'd4);
    chk("post_rst_opcode", {26'd0, opcode}, 32'h03);
    RegDst = 2'b10; MemtoReg = 2'b10; RegWrite = 1;
    tick();
    idle();
    read_reg(5'd31, res); chk("jal_rf31", res, 32'd4);
    read_reg(5'd9, res);  chk("rst_cleared_rf9", res, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
